// File: rtl/valid_flush_writer_if.sv
// rtl/valid_flush_writer_if.sv - request/grant and valid-array bus bundle for valid_flush_writer
interface valid_flush_writer_if #(
  parameter int INDEX_W = 10
);
  logic               flush_req;
  logic               flush_busy;
  logic               flush_done;
  logic               inv_req;
  logic [INDEX_W-1:0] inv_addr;
  logic               inv_gnt;
  logic               fill_req;
  logic [INDEX_W-1:0] fill_addr;
  logic               fill_gnt;
  logic               vm_wrEn;
  logic [INDEX_W-1:0] vm_address;
  logic               vm_inValidity;
  logic               vm_isValid;
  logic [INDEX_W:0]   flush_valid_count;

  modport master (
    output flush_req, inv_req, inv_addr, fill_req, fill_addr, vm_isValid,
    input  flush_busy, flush_done, inv_gnt, fill_gnt,
    input  vm_wrEn, vm_address, vm_inValidity, flush_valid_count
  );

  modport slave (
    input  flush_req, inv_req, inv_addr, fill_req, fill_addr, vm_isValid,
    output flush_busy, flush_done, inv_gnt, fill_gnt,
    output vm_wrEn, vm_address, vm_inValidity, flush_valid_count
  );
endinterface

// File: rtl/valid_flush_writer.sv
// rtl/valid_flush_writer.sv - sole writer of the cache valid-bit array: fill, invalidate, full flush
// Optional flush-time valid-line statistic enabled by defining FLUSH_VALID_COUNT_EN.
module valid_flush_writer #(
  parameter int INDEX_W = 10,
  parameter int LINES   = 1024
) (
  input logic             globalclock,
  input logic             reset_n,
  valid_flush_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(LINES - 1);

  state_t             state_q, state_d;
  logic               wr_en_q, wr_en_d;
  logic [INDEX_W-1:0] addr_q, addr_d;
  logic               data_q, data_d;
  logic               done_q, done_d;
  logic               inv_gnt, fill_gnt;

  always_ff @(posedge globalclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Grants are combinational so the requester's write registers on the same edge.
  always_comb begin
    state_d  = state_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = 1'b0;
    inv_gnt  = 1'b0;
    fill_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          wr_en_d = 1'b1;
          addr_d  = '0;
          data_d  = 1'b0;
        end else if (bus.inv_req) begin
          inv_gnt = 1'b1;
          wr_en_d = 1'b1;
          addr_d  = bus.inv_addr;
          data_d  = 1'b0;
        end else if (bus.fill_req) begin
          fill_gnt = 1'b1;
          wr_en_d  = 1'b1;
          addr_d   = bus.fill_addr;
          data_d   = 1'b1;
        end
      end
      FLUSH: begin
        if (addr_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = addr_q + 1'b1;
          data_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.inv_gnt       = inv_gnt;
  assign bus.fill_gnt      = fill_gnt;
  assign bus.flush_busy    = (state_q != IDLE);
  assign bus.flush_done    = done_q;
  assign bus.vm_wrEn       = wr_en_q;
  assign bus.vm_address    = addr_q;
  assign bus.vm_inValidity = data_q;

`ifdef FLUSH_VALID_COUNT_EN
  logic [INDEX_W:0] count_q, count_d;

  // vm_isValid shows the pre-clear value of the line being written this cycle.
  always_comb begin
    count_d = count_q;
    if (state_q == IDLE && bus.flush_req) begin
      count_d = '0;
    end else if (state_q == FLUSH && wr_en_q && bus.vm_isValid) begin
      count_d = count_q + (INDEX_W+1)'(1);
    end
  end

  always_ff @(posedge globalclock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.flush_valid_count = count_q;
`else
  assign bus.flush_valid_count = '0;
`endif

endmodule

// File: tb/tb_valid_flush_writer.sv
// tb/tb_valid_flush_writer.sv - directed and randomized checks of valid_flush_writer against a valid-array model
module tb_valid_flush_writer;

  localparam int IW = 4;
  localparam int NL = 16;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic model_v [NL];
  logic mem     [NL];

  valid_flush_writer_if #(.INDEX_W(IW)) bus ();

  valid_flush_writer #(.INDEX_W(IW), .LINES(NL)) dut (
    .globalclock (clk),
    .reset_n     (rst_n),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour of the valid-bit array the writer drives.
  always @(posedge clk) begin
    if (bus.vm_wrEn) mem[bus.vm_address] <= bus.vm_inValidity;
  end
  assign bus.vm_isValid = mem[bus.vm_address];

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int valid_lines();
    int n = 0;
    for (int i = 0; i < NL; i++) n += int'(model_v[i]);
    return n;
  endfunction

  function automatic int exp_count(input int n);
`ifdef FLUSH_VALID_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk_array(input string tag);
    for (int i = 0; i < NL; i++) chk($sformatf("%s[%0d]", tag, i), 32'(mem[i]), 32'(model_v[i]));
  endtask

  task automatic single(input bit is_inv, input logic [IW-1:0] a);
    if (is_inv) begin bus.inv_req = 1'b1; bus.inv_addr = a; end
    else begin bus.fill_req = 1'b1; bus.fill_addr = a; end
    #1;
    chk("single_inv_gnt", 32'(bus.inv_gnt), 32'(is_inv));
    chk("single_fill_gnt", 32'(bus.fill_gnt), 32'(!is_inv));
    step();
    bus.inv_req = 1'b0;
    bus.fill_req = 1'b0;
    chk("single_wr", 32'(bus.vm_wrEn), 1);
    chk("single_addr", 32'(bus.vm_address), 32'(a));
    chk("single_data", 32'(bus.vm_inValidity), 32'(!is_inv));
    model_v[a] = !is_inv;
  endtask

  // Both requesters raised together: invalidate first, fill on the next cycle.
  task automatic both(input logic [IW-1:0] ia, input logic [IW-1:0] fa);
    bus.inv_req = 1'b1; bus.inv_addr = ia;
    bus.fill_req = 1'b1; bus.fill_addr = fa;
    #1;
    chk("both_inv_gnt", 32'(bus.inv_gnt), 1);
    chk("both_fill_gnt0", 32'(bus.fill_gnt), 0);
    step();
    bus.inv_req = 1'b0;
    chk("both_inv_wr", 32'(bus.vm_wrEn), 1);
    chk("both_inv_addr", 32'(bus.vm_address), 32'(ia));
    chk("both_inv_data", 32'(bus.vm_inValidity), 0);
    model_v[ia] = 1'b0;
    #1;
    chk("both_fill_gnt1", 32'(bus.fill_gnt), 1);
    step();
    bus.fill_req = 1'b0;
    chk("both_fill_addr", 32'(bus.vm_address), 32'(fa));
    chk("both_fill_data", 32'(bus.vm_inValidity), 1);
    model_v[fa] = 1'b1;
  endtask

  task automatic run_flush(input int fill_at, input logic [IW-1:0] faddr);
    int n;
    n = valid_lines();
    bus.flush_req = 1'b1;
    #1;
    chk("fstart_inv_gnt", 32'(bus.inv_gnt), 0);
    chk("fstart_fill_gnt", 32'(bus.fill_gnt), 0);
    chk("fstart_busy", 32'(bus.flush_busy), 0);
    step();
    bus.flush_req = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (i == fill_at) begin bus.fill_req = 1'b1; bus.fill_addr = faddr; end
      #1;
      chk($sformatf("fl_wr%0d", i), 32'(bus.vm_wrEn), 1);
      chk($sformatf("fl_addr%0d", i), 32'(bus.vm_address), 32'(i));
      chk($sformatf("fl_data%0d", i), 32'(bus.vm_inValidity), 0);
      chk($sformatf("fl_busy%0d", i), 32'(bus.flush_busy), 1);
      chk($sformatf("fl_done%0d", i), 32'(bus.flush_done), 0);
      chk($sformatf("fl_gnt%0d", i), 32'({bus.inv_gnt, bus.fill_gnt}), 0);
      model_v[i] = 1'b0;
      step();
    end
    chk("done_pulse", 32'(bus.flush_done), 1);
    chk("done_wr", 32'(bus.vm_wrEn), 0);
    chk("done_busy", 32'(bus.flush_busy), 1);
    chk("done_addr_hold", 32'(bus.vm_address), NL - 1);
    chk("done_gnt", 32'({bus.inv_gnt, bus.fill_gnt}), 0);
    chk("done_count", 32'(bus.flush_valid_count), 32'(exp_count(n)));
    step();
    chk("post_done", 32'(bus.flush_done), 0);
    chk("post_busy", 32'(bus.flush_busy), 0);
    chk("post_count_hold", 32'(bus.flush_valid_count), 32'(exp_count(n)));
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin mem[i] = 1'b0; model_v[i] = 1'b0; end
    rst_n = 1'b0;
    bus.flush_req = 1'b0;
    bus.inv_req = 1'b0;
    bus.inv_addr = '0;
    bus.fill_req = 1'b0;
    bus.fill_addr = '0;
    repeat (3) step();
    chk("rst_wr", 32'(bus.vm_wrEn), 0);
    chk("rst_addr", 32'(bus.vm_address), 0);
    chk("rst_data", 32'(bus.vm_inValidity), 0);
    rst_n = 1'b1;
    step();
    chk("idle_wr", 32'(bus.vm_wrEn), 0);
    chk("idle_done", 32'(bus.flush_done), 0);
    chk("idle_busy", 32'(bus.flush_busy), 0);
    chk("idle_count", 32'(bus.flush_valid_count), 0);
    chk("idle_gnt", 32'({bus.inv_gnt, bus.fill_gnt}), 0);

    single(1'b0, 4'd5);
    step();
    chk("fill5_wr_drop", 32'(bus.vm_wrEn), 0);
    chk("fill5_addr_hold", 32'(bus.vm_address), 5);
    chk("fill5_data_hold", 32'(bus.vm_inValidity), 1);
    chk_array("arr_fill5");

    run_flush(-1, '0);
    chk_array("arr_flush1");

    // Priority: all three requests in one IDLE cycle; inv/fill held through the flush.
    bus.inv_req = 1'b1; bus.inv_addr = 4'd2;
    bus.fill_req = 1'b1; bus.fill_addr = 4'd9;
    run_flush(-1, '0);
    both(4'd2, 4'd9);
    step();
    chk_array("arr_prio");

    // Interlock: fill raised in flush cycle 3, granted on first IDLE cycle.
    run_flush(3, 4'd12);
    #1;
    chk("lock_fill_gnt", 32'(bus.fill_gnt), 1);
    step();
    bus.fill_req = 1'b0;
    chk("lock_fill_addr", 32'(bus.vm_address), 12);
    chk("lock_fill_data", 32'(bus.vm_inValidity), 1);
    model_v[12] = 1'b1;
    step();

    // Abort a flush while it is writing address 7.
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    for (int i = 0; i < 7; i++) begin model_v[i] = 1'b0; step(); end
    chk("abort_at7", 32'(bus.vm_address), 7);
    rst_n = 1'b0;
    #1;
    chk("abort_wr", 32'(bus.vm_wrEn), 0);
    chk("abort_busy", 32'(bus.flush_busy), 0);
    chk("abort_done", 32'(bus.flush_done), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_abort", 32'({bus.vm_wrEn, bus.flush_done, bus.flush_busy}), 0);
    end
    chk("abort_count", 32'(bus.flush_valid_count), 0);
    chk_array("arr_abort");

    run_flush(-1, '0);
    single(1'b0, 4'd1);
    single(1'b0, 4'd4);
    single(1'b0, 4'd4);
    single(1'b0, 4'd15);
    step();
    chk("three_valid_model", 32'(valid_lines()), 3);
    run_flush(-1, '0);
    run_flush(-1, '0);

    // Randomized fill/invalidate traffic, each round closed by a checked flush.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 12; k++) begin
        int kind;
        kind = int'($urandom_range(0, 2));
        if (kind == 2) both(IW'($urandom_range(0, NL-1)), IW'($urandom_range(0, NL-1)));
        else single(kind == 1, IW'($urandom_range(0, NL-1)));
      end
      step();
      chk_array($sformatf("arr_rand%0d", r));
      run_flush(-1, '0);
      chk_array($sformatf("arr_rflush%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
